// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b ALU op, control word and EX-stage FSM state types
//   lc3b_aluop        : ALU operation select, including the iterative multiply
//   lc3b_control_word : decoded control word; the EX stage uses aluop and alumux_sel
//   ex_state_t        : EX-stage handshake/multiply FSM states
package lc3b_types;

    typedef enum logic [2:0] {
        alu_add,
        alu_and,
        alu_not,
        alu_pass,
        alu_sll,
        alu_srl,
        alu_sra,
        alu_mul
    } lc3b_aluop;

    typedef struct packed {
        lc3b_aluop  aluop;
        logic [1:0] alumux_sel;
    } lc3b_control_word;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        HOLD
    } ex_state_t;

endpackage

// File: rtl/alu.sv
// alu: single-cycle LC-3b ALU
//   aluop : operation select (alu_mul falls through to pass A)
//   a, b  : operands; shifts use b[3:0] as the amount
//   f     : result, truncated to WIDTH
module alu
    import lc3b_types::*;
#(
    parameter int WIDTH = 16
) (
    input  lc3b_aluop        aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f
);

    logic [3:0] sh;

    assign sh = b[3:0];

    always_comb begin
        case (aluop)
            alu_add: f = a + b;
            alu_and: f = a & b;
            alu_not: f = ~a;
            alu_sll: f = a << sh;
            alu_srl: f = a >> sh;
            alu_sra: f = $unsigned($signed(a) >>> sh);
            default: f = a;
        endcase
    end

endmodule

// File: rtl/mul_iter.sv
// mul_iter: shift-add multiplier producing the low WIDTH bits of a*b in WIDTH cycles
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : capture a and b and begin a multiply
//   a, b       : operands
//   done       : last iteration this cycle; product is valid while done is high
//   product    : low WIDTH bits of a*b (combinational, valid with done)
module mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic             run;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] addend;

    // The final iteration is folded into the combinational product so the
    // caller can register the result on the WIDTH-th edge after start.
    assign addend  = mplier[0] ? mcand : '0;
    assign product = acc + addend;
    assign done    = run && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run    <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (run) begin
            run    <= !done;
            cnt    <= cnt + CW'(1);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= product;
        end
    end

endmodule

// File: rtl/ex_pipe.sv
// ex_pipe: LC-3b execute stage with valid/ready handshake and optional iterative multiply
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid, in_ready     : upstream handshake; a transfer captures all operands
//   ctrl                   : control word (aluop, alumux_sel)
//   pc, adj                : PC and sign-extended offset
//   sr1, sr2, sr2real      : operand A, immediate operand, register SR2 value
//   out_valid, out_ready   : downstream handshake
//   addpcadj_out, alu_out  : registered pc+adj and ALU result
//   busy                   : multiply in progress
module ex_pipe
    import lc3b_types::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  lc3b_control_word ctrl,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] adj,
    input  logic [WIDTH-1:0] sr1,
    input  logic [WIDTH-1:0] sr2,
    input  logic [WIDTH-1:0] sr2real,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] addpcadj_out,
    output logic [WIDTH-1:0] alu_out,
    output logic             busy
);

    ex_state_t        state;
    ex_state_t        state_next;
    logic             xfer;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu_f;
    logic [WIDTH-1:0] mul_p;

    assign b         = |ctrl.alumux_sel ? sr2 : sr2real;
    assign is_mul    = (MUL_EN != 0) && (ctrl.aluop == alu_mul);
    // rst_n gates in_ready so nothing is accepted while reset is held
    assign in_ready  = rst_n && (state == IDLE || (state == HOLD && out_ready));
    assign xfer      = in_valid && in_ready;
    assign out_valid = state == HOLD;
    assign busy      = state == MUL;

    alu #(.WIDTH(WIDTH)) u_alu (
        .aluop (ctrl.aluop),
        .a     (sr1),
        .b     (b),
        .f     (alu_f)
    );

    generate
        if (MUL_EN != 0) begin : g_mul
            mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (xfer && is_mul),
                .a       (sr1),
                .b       (b),
                .done    (mul_done),
                .product (mul_p)
            );
        end else begin : g_nomul
            assign mul_done = 1'b0;
            assign mul_p    = '0;
        end
    endgenerate

    // A transfer always wins: in HOLD it doubles as the consume, giving no bubble.
    always_comb begin
        state_next = xfer ? (is_mul ? MUL : HOLD) :
                     (state == MUL) ? (mul_done ? HOLD : MUL) :
                     (state == HOLD && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addpcadj_out <= '0;
            alu_out      <= '0;
        end else begin
            if (xfer) addpcadj_out <= pc + adj;
            if (xfer && !is_mul) alu_out <= alu_f;
            else if (mul_done)   alu_out <= mul_p;
        end
    end

endmodule
